// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the multiply/divide unit (mdu_hilo).
//   mdu_op_t    : operation encoding as it arrives on the op port
//   mdu_state_t : sequencer states
//   MDU_ITER    : iteration cycles per operation (one per operand bit)
//   abs32       : two's-complement magnitude of a 32-bit value
// No ports (package).
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Magnitude of a signed 32-bit value. 0x80000000 maps to itself, which is
    // the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        if (v[31]) begin
            abs32 = ~v + 32'd1;
        end else begin
            abs32 = v;
        end
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// -----------------------------------------------------------------------------
// mdu_hilo_if
// Request/result bundle between decode/execute and the multiply/divide unit.
//   start, op, rs_data, rt_data : operation launch and operands
//   mthi, mtlo                  : direct writes of rs_data into HI / LO
//   rd_req                      : decode holds MFHI/MFLO
//   hi, lo                      : architectural HI/LO
//   busy, done, stall           : status back to the pipeline
// master = pipeline side, slave = mdu_hilo.
// -----------------------------------------------------------------------------
interface mdu_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, rd_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, rd_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mdu_divstep.sv
// -----------------------------------------------------------------------------
// mdu_divstep
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder (33-bit trial value) and subtract the divisor if it
// fits.
//   part_rem : current partial remainder (always < divisor, so 32 bits)
//   next_bit : next dividend bit, MSB first
//   divisor  : divisor magnitude
//   new_rem  : updated partial remainder
//   quo_bit  : quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_divstep (
    input  logic [31:0] part_rem,
    input  logic        next_bit,
    input  logic [31:0] divisor,
    output logic [31:0] new_rem,
    output logic        quo_bit
);

    logic [32:0] trial_s;

    // Trial subtraction; the difference fits in 32 bits whenever it is taken.
    always_comb begin
        trial_s = {part_rem, next_bit};
        quo_bit = (trial_s >= {1'b0, divisor});
        if (quo_bit) begin
            new_rem = trial_s[31:0] - divisor;
        end else begin
            new_rem = trial_s[31:0];
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use LSB-first shift-add, DIV/DIVU use MSB-first restoring
// division on operand magnitudes; signs are applied in a final FIX cycle.
// Result: mult HI:LO = product; div LO = quotient, HI = remainder.
// Ports: clk, rst (synchronous, active-high), bus (mdu_hilo_if.slave).
// Build option: define MDU_FAST_MULT_EN to compute MULT/MULTU in a single
// cycle (HI/LO written at the start edge, busy stays low); divides remain
// iterative.
// -----------------------------------------------------------------------------
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);

    localparam int CW = $clog2(ITER);

    mdu_state_t  state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0] mcand_r;     // multiplicand (mult) or divisor (div) magnitude
    logic [63:0] prod_r;      // mult: {partial sum, multiplier}; div: [31:0] dividend->quotient
    logic [31:0] rem_r;
    logic        is_div_r;
    logic        neg_res_r;
    logic        neg_rem_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    mdu_op_t     op_s;
    logic        signed_s;
    logic        div_op_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        launch_s;
    logic        fast_wr_s;
    logic [63:0] fast_prod_s;
    logic [32:0] mul_sum_s;
    logic [31:0] new_rem_s;
    logic        qbit_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    mdu_divstep u_divstep (
        .part_rem (rem_r),
        .next_bit (prod_r[31]),
        .divisor  (mcand_r),
        .new_rem  (new_rem_s),
        .quo_bit  (qbit_s)
    );

    // Decode the request and form operand magnitudes.
    always_comb begin
        op_s     = mdu_op_t'(bus.op);
        signed_s = (op_s == MDU_MULT) || (op_s == MDU_DIV);
        div_op_s = (op_s == MDU_DIV) || (op_s == MDU_DIVU);
        if (signed_s) begin
            mag_a_s = abs32(bus.rs_data);
            mag_b_s = abs32(bus.rt_data);
        end else begin
            mag_a_s = bus.rs_data;
            mag_b_s = bus.rt_data;
        end
    end

    // Choose between the single-cycle multiply and the iterative launch.
    always_comb begin
        fast_prod_s = 64'd0;
`ifdef MDU_FAST_MULT_EN
        if (signed_s) begin
            fast_prod_s = {{32{bus.rs_data[31]}}, bus.rs_data} * {{32{bus.rt_data[31]}}, bus.rt_data};
        end else begin
            fast_prod_s = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
        end
        fast_wr_s = (state_r == IDLE) && bus.start && !div_op_s;
`else
        fast_wr_s = 1'b0;
`endif
        launch_s = (state_r == IDLE) && bus.start && !fast_wr_s;
    end

    // Shift-add partial sum; the carry lands in bit 63 after the shift.
    always_comb begin
        if (prod_r[0]) begin
            mul_sum_s = {1'b0, prod_r[63:32]} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, prod_r[63:32]};
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        fix_hi_s = 32'd0;
        fix_lo_s = 32'd0;
        if (is_div_r) begin
            if (neg_res_r) begin
                fix_lo_s = ~prod_r[31:0] + 32'd1;
            end else begin
                fix_lo_s = prod_r[31:0];
            end
            if (neg_rem_r) begin
                fix_hi_s = ~rem_r + 32'd1;
            end else begin
                fix_hi_s = rem_r;
            end
        end else begin
            if (neg_res_r) begin
                {fix_hi_s, fix_lo_s} = ~prod_r + 64'd1;
            end else begin
                {fix_hi_s, fix_lo_s} = prod_r;
            end
        end
    end

    // Sequencer, datapath registers and HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            mcand_r   <= 32'd0;
            prod_r    <= 64'd0;
            rem_r     <= 32'd0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        is_div_r  <= div_op_s;
                        neg_res_r <= signed_s & (bus.rs_data[31] ^ bus.rt_data[31]);
                        neg_rem_r <= signed_s & div_op_s & bus.rs_data[31];
                        rem_r     <= 32'd0;
                        cnt_r     <= CW'(ITER - 1);
                        busy_r    <= 1'b1;
                        state_r   <= CALC;
                        if (div_op_s) begin
                            mcand_r <= mag_b_s;
                            prod_r  <= {32'd0, mag_a_s};
                        end else begin
                            mcand_r <= mag_a_s;
                            prod_r  <= {32'd0, mag_b_s};
                        end
                    end else if (fast_wr_s) begin
                        {hi_r, lo_r} <= fast_prod_s;
                        done_r       <= 1'b1;
                    end else begin
                        if (bus.mthi) begin
                            hi_r <= bus.rs_data;
                        end
                        if (bus.mtlo) begin
                            lo_r <= bus.rs_data;
                        end
                    end
                end
                CALC: begin
                    if (is_div_r) begin
                        prod_r[31:0] <= {prod_r[30:0], qbit_s};
                        rem_r        <= new_rem_s;
                    end else begin
                        prod_r <= {mul_sum_s, prod_r[31:1]};
                    end
                    if (cnt_r == '0) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.stall = bus.rd_req & busy_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo
// Directed bench for mdu_hilo. A cycle-level reference model derived from the
// architectural rules (plain 64-bit arithmetic, fixed 33-cycle latency) is
// compared against hi/lo/busy/done/stall on every falling edge; hand-computed
// literals pin the results of each directed operation.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic chk_en;

    mdu_hilo_if bus();

    mdu_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: ref_result = sa * sb;
            2'd1: ref_result = ua * ub;
            2'd2: begin
                if (b == 32'd0) begin
                    // all-ones magnitude quotient, negated for a negative dividend
                    ref_result = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
                else            ref_result = {a % b, a / b};
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done;
    int          m_left;
    logic [63:0] m_res;

    initial begin
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
        m_done = 1'b0; m_left = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (bus.start) begin
                m_res = ref_result(bus.op, bus.rs_data, bus.rt_data);
`ifdef MDU_FAST_MULT_EN
                if (bus.op < 2'd2) begin
                    m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_done = 1'b1;
                end else begin
                    p_hi = m_res[63:32]; p_lo = m_res[31:0]; m_left = 33;
                end
`else
                p_hi = m_res[63:32]; p_lo = m_res[31:0]; m_left = 33;
`endif
            end else begin
                if (bus.mthi) m_hi = bus.rs_data;
                if (bus.mtlo) m_lo = bus.rs_data;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
            check("busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            check("stall", {31'd0, bus.stall}, {31'd0, bus.rd_req && (m_left != 0)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mvhi, input logic mvlo, input logic go);
        @(posedge clk); #1;
        bus.start = go; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        bus.mthi = mvhi; bus.mtlo = mvlo;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        logic seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb;
        issue(op, a, b, 1'b0, 1'b0, 1'b1);
        wait_done(nb);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int nb;
        n_cmp = 0; n_err = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.rd_req = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);

        // MULTU max x max, with latency measurement
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        wait_done(nb);
`ifdef MDU_FAST_MULT_EN
        check("multu_busy_cycles", nb, 32'd0);
`else
        check("multu_busy_cycles", nb, 32'd33);
`endif
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        run_op("mult_m7x3", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min2", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1);
        wait_done(nb);
        check("div_busy_cycles", nb, 32'd33);
        check("div_m7d2_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_m7d2_lo", bus.lo, 32'hFFFF_FFFD);

        run_op("div_7dm2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_100d0", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu_big", 2'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);

        // rd_req held through a DIVU; a second start and an mthi mid-op are ignored
        bus.rd_req = 1'b1;
        issue(2'd3, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("stall_mid", {31'd0, bus.stall}, 32'd1);
        issue(2'd3, 32'd5, 32'd1, 1'b0, 1'b0, 1'b1);
        issue(2'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_done(nb);
        check("divu_first_hi", bus.hi, 32'd6);
        check("divu_first_lo", bus.lo, 32'd142);
        check("stall_after", {31'd0, bus.stall}, 32'd0);
        bus.rd_req = 1'b0;

        // moves in IDLE
        issue(2'd0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        issue(2'd0, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("mthilo_hi", bus.hi, 32'hA5A5_A5A5);
        check("mthilo_lo", bus.lo, 32'hA5A5_A5A5);

        // mtlo together with start: the move is dropped
        issue(2'd1, 32'd6, 32'd7, 1'b0, 1'b1, 1'b1);
        wait_done(nb);
        check("start_mtlo_lo", bus.lo, 32'd42);
        check("start_mtlo_hi", bus.hi, 32'd0);

        // reset in the middle of a DIV
        issue(2'd2, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (40) @(negedge clk);

`ifdef MDU_FAST_MULT_EN
        issue(2'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("fast_lo", bus.lo, 32'd15);
        check("fast_done", {31'd0, bus.done}, 32'd1);
        check("fast_busy", {31'd0, bus.busy}, 32'd0);
`else
        run_op("multu_3x5", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15);
`endif
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Consumes the two register-file read operands (rs, rt) on MULT, MULTU, DIV and DIVU. Produces the 64-bit result in HI/LO over a fixed multi-cycle latency. Provides a stall request so MFHI/MFLO in decode wait until the operation completes.

## Interface
Parameters:
- ITER, 32, number of iteration cycles per operation (fixed at operand width; not intended to change)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch operation selected by op (single-cycle request)
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_data  in  32  operand A (multiplicand / dividend), from register-file read port 1
- rt_data  in  32  operand B (multiplier / divisor), from register-file read port 2
- mthi  in  1  write rs_data into HI
- mtlo  in  1  write rs_data into LO
- rd_req  in  1  decode holds MFHI or MFLO
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO receive a result
- stall  out  1  rd_req & busy (combinational)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1: latch op. Latch |rs_data| and |rt_data| (signed ops) or the raw values (unsigned ops). Latch result-sign flags. Counter := ITER-1. Go to CALC.
- CALC, multiply: shift-add over a 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder.
- CALC exit: when the counter reaches 0, go to FIX.
- FIX:
  - Negate the product if the operand signs differ (signed mult).
  - Negate the quotient if the signs differ (signed div).
  - Remainder takes the sign of the dividend.
  - Write HI/LO, pulse done, go to IDLE.
- Result mapping: mult HI:LO = 64-bit product; div LO = quotient, HI = remainder.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend (unsigned magnitude path, then sign-fixed as above for DIV). No exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start while busy: ignored.
- mthi/mtlo: act only in IDLE; ignored while busy.
- start together with mthi/mtlo in IDLE: start wins, the move is dropped.
- mthi and mtlo together: both written.
- HI/LO hold their value between writes; they never show intermediate values.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. stall follows rd_req & busy, so it is 0 out of reset.
- rst asserted in any state: at the next edge, abort the operation and return to the reset values. No done pulse.
- Operation timing (iterative path), with start sampled at edge E0:
  - busy is high from after E0 through E33 (33 cycles: 32 CALC + 1 FIX).
  - HI/LO are updated at edge E33.
  - done is high during the cycle after E33.
  - A new start is accepted in that same cycle.
- Move timing: mthi/mtlo update at the sampling edge; the value is visible the next cycle.
- Forwarding: no internal forwarding from a pending result. The consumer must honour stall.

## Configuration
- MDU_FAST_MULT_EN defined:
  - MULT/MULTU compute combinationally and write HI/LO at the start edge E0.
  - done pulses the following cycle; busy stays 0.
  - DIV/DIVU are unchanged (iterative).
- MDU_FAST_MULT_EN undefined: every operation takes the 33-cycle iterative path above.

## Structure
- Package mdu_pkg:
  - mdu_op_t enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - mdu_state_t enum (IDLE, CALC, FIX)
  - localparam MDU_ITER = 32
  - function abs32 for the magnitude conversion
- Sub-module mdu_divstep: combinational single restoring-division step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- Top module holds the FSM, counter, multiply datapath and HI/LO registers.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001; done pulses once.
- MULT -7 × 3 (0xFFFFFFF9, 3) → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- rd_req held during a DIVU → stall=1 exactly while busy=1. A start issued mid-operation is ignored; the final result reflects the first operands.
- mthi 0x12345678 in IDLE → hi=0x12345678 next cycle. mtlo asserted together with start → LO is overwritten only by the op result.
- rst asserted at cycle 10 of a DIV → next cycle hi=lo=0, busy=0, no done. With MDU_FAST_MULT_EN, MULTU 3×5 → LO=15 one cycle after start, busy never high.
